// File: rtl/result_streamer.sv
// Snapshot buffer that streams the valid N x M region of a matrix-multiply result over valid/ready.
// Optional macro RESULT_STREAM_PARITY_EN adds out_parity_o (XOR of out_data_o).
module result_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int DIM_WIDTH  = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  done_i,
  input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0] res_i,
  input  logic [DIM_WIDTH-1:0]                  dim_n_i,
  input  logic [DIM_WIDTH-1:0]                  dim_m_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [DATA_WIDTH-1:0]                 out_data_o,
  output logic [DIM_WIDTH-1:0]                  out_row_o,
  output logic [DIM_WIDTH-1:0]                  out_col_o,
  output logic                                  out_last_o,
  output logic                                  busy_o,
  output logic                                  overflow_o
`ifdef RESULT_STREAM_PARITY_EN
  ,
  output logic                                  out_parity_o
`endif
);

  localparam int ELEMS = MAX_DIM * MAX_DIM;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   buf_q [ELEMS];
  logic [DIM_WIDTH-1:0]    row_q, col_q;
  logic [DIM_WIDTH-1:0]    n_max_q, m_max_q;
  logic                    overflow_q;

  logic                    streaming, xfer, row_end, at_last, finish, load;
  logic [IDX_W-1:0]        rd_idx;

  // Dimensions are held as (dim - 1) after clamping 0 -> 1 and >MAX_DIM -> MAX_DIM.
  function automatic logic [DIM_WIDTH-1:0] dim_max(input logic [DIM_WIDTH-1:0] d);
    if (d == '0) return '0;
    else if (d > DIM_WIDTH'(MAX_DIM)) return DIM_WIDTH'(MAX_DIM - 1);
    else return d - DIM_WIDTH'(1);
  endfunction

  // Handshake: a beat moves on every cycle where out_valid_o && out_ready_i;
  // valid only drops after the last beat transfers, and ready is ignored while valid is low.
  assign streaming = (state_q == STREAM);
  assign xfer      = streaming && out_ready_i;
  assign row_end   = (col_q == m_max_q);
  assign at_last   = row_end && (row_q == n_max_q);
  assign finish    = xfer && at_last;
  assign load      = done_i && (!streaming || finish);
  assign rd_idx    = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      n_max_q    <= '0;
      m_max_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < ELEMS; k++) buf_q[k] <= '0;
    end else begin
      if (load) begin
        for (int k = 0; k < ELEMS; k++) buf_q[k] <= res_i[k*DATA_WIDTH +: DATA_WIDTH];
        n_max_q <= dim_max(dim_n_i);
        m_max_q <= dim_max(dim_m_i);
      end

      if (load || finish) begin
        row_q <= '0;
        col_q <= '0;
      end else if (xfer) begin
        if (row_end) begin
          col_q <= '0;
          row_q <= row_q + DIM_WIDTH'(1);
        end else begin
          col_q <= col_q + DIM_WIDTH'(1);
        end
      end

      // A job arriving mid-stream is dropped; one landing on the last beat chains on.
      if (done_i && streaming && !finish) overflow_q <= 1'b1;

      unique case (state_q)
        IDLE:    if (load) state_q <= STREAM;
        STREAM:  if (finish && !load) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = streaming;
  assign busy_o      = streaming;
  assign out_data_o  = streaming ? buf_q[rd_idx] : '0;
  assign out_row_o   = streaming ? row_q : '0;
  assign out_col_o   = streaming ? col_q : '0;
  assign out_last_o  = streaming && at_last;
  assign overflow_o  = overflow_q;

`ifdef RESULT_STREAM_PARITY_EN
  assign out_parity_o = ^out_data_o;
`endif

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: table-driven jobs, randomized jobs, and hand-written
// back-to-back, overflow and mid-stream reset sequences against a queue-based model.
module tb_result_streamer;

  localparam int DW    = 32;
  localparam int MD    = 4;
  localparam int DIMW  = 3;
  localparam int RES_W = DW * MD * MD;
  localparam int BW    = DW + 2 * DIMW + 1;

  logic             clk, rst_n, done, out_ready;
  logic [RES_W-1:0] res;
  logic [DIMW-1:0]  dim_n, dim_m;
  logic             out_valid, out_last, busy, overflow;
  logic [DW-1:0]    out_data;
  logic [DIMW-1:0]  out_row, out_col;
`ifdef RESULT_STREAM_PARITY_EN
  logic             out_parity;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [BW-1:0] exp_q[$];

  typedef struct {
    int n;
    int m;
    int pat;
    int mode;
    int exp_beats;
  } vec_t;
  vec_t tbl[7];

  result_streamer #(.DATA_WIDTH(DW), .MAX_DIM(MD), .DIM_WIDTH(DIMW)) dut (
`ifdef RESULT_STREAM_PARITY_EN
    .out_parity_o(out_parity),
`endif
    .clk_i(clk),
    .rst_ni(rst_n),
    .done_i(done),
    .res_i(res),
    .dim_n_i(dim_n),
    .dim_m_i(dim_m),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o(out_data),
    .out_row_o(out_row),
    .out_col_o(out_col),
    .out_last_o(out_last),
    .busy_o(busy),
    .overflow_o(overflow)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the stream is the clamped N x M region in row-major order.
  task automatic push_expected(input logic [DIMW-1:0] n, input logic [DIMW-1:0] m,
                               input logic [RES_W-1:0] r);
    int nc, mc, k;
    nc = (n == 0) ? 1 : ((int'(n) > MD) ? MD : int'(n));
    mc = (m == 0) ? 1 : ((int'(m) > MD) ? MD : int'(m));
    for (int rr = 0; rr < nc; rr++)
      for (int cc = 0; cc < mc; cc++) begin
        k = rr * MD + cc;
        exp_q.push_back({r[k*DW +: DW], 3'(rr), 3'(cc), (rr == nc - 1) && (cc == mc - 1)});
      end
  endtask

  task automatic make_res(input int pat, output logic [RES_W-1:0] r);
    for (int k = 0; k < MD * MD; k++)
      case (pat)
        0:       r[k*DW +: DW] = 32'(100 + k);
        1:       r[k*DW +: DW] = 32'(k);
        default: r[k*DW +: DW] = $urandom();
      endcase
  endtask

  // Driver: pulse done for one cycle, then scramble res_i to prove the snapshot holds.
  task automatic start_job(input logic [DIMW-1:0] n, input logic [DIMW-1:0] m,
                           input logic [RES_W-1:0] r);
    logic [RES_W-1:0] junk;
    done = 1'b1; dim_n = n; dim_m = m; res = r;
    push_expected(n, m, r);
    @(negedge clk);
    done = 1'b0;
    make_res(2, junk);
    res = junk;
  endtask

  // Drives ready per mode (0: always, 1: 1,0,0,1 pattern, 2: random) and scores every beat.
  task automatic drain(input int mode, input int budget, input int inj_at,
                       input logic [DIMW-1:0] inj_n, input logic [DIMW-1:0] inj_m,
                       input logic [RES_W-1:0] inj_res, input bit inj_accept,
                       output int beats, output int cycles);
    logic [BW-1:0] cur, prev, e;
    bit prev_stall, rdy;
    int phase;
    beats = 0; cycles = 0; prev_stall = 0; prev = '0; phase = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      done = 1'b0;
      cur = {out_data, out_row, out_col, out_last};
      check("valid_in_job", 64'(out_valid), 64'(1));
      check("busy_in_job", 64'(busy), 64'(1));
      if (prev_stall) check("stall_hold", 64'(cur), 64'(prev));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 4 == 0) || (phase % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      out_ready = rdy;
      if (cycles == inj_at) begin
        done = 1'b1; dim_n = inj_n; dim_m = inj_m; res = inj_res;
      end
      if (out_valid && rdy) begin
        beats++;
        e = exp_q.pop_front();
        check("beat", 64'(cur), 64'(e));
`ifdef RESULT_STREAM_PARITY_EN
        check("parity", 64'(out_parity), 64'(^e[BW-1:2*DIMW+1]));
`endif
      end
      if (cycles == inj_at && inj_accept) push_expected(inj_n, inj_m, inj_res);
      prev_stall = out_valid && !rdy;
      prev = cur;
      @(negedge clk);
      cycles++;
    end
    done = 1'b0;
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [RES_W-1:0] r, r2;
    int beats, cyc;

    tbl[0] = '{n: 4, m: 4, pat: 0, mode: 0, exp_beats: 16};
    tbl[1] = '{n: 2, m: 3, pat: 1, mode: 0, exp_beats: 6};
    tbl[2] = '{n: 4, m: 4, pat: 0, mode: 1, exp_beats: 16};
    tbl[3] = '{n: 0, m: 0, pat: 2, mode: 2, exp_beats: 1};
    tbl[4] = '{n: 7, m: 5, pat: 2, mode: 2, exp_beats: 16};
    tbl[5] = '{n: 1, m: 4, pat: 2, mode: 0, exp_beats: 4};
    tbl[6] = '{n: 3, m: 6, pat: 2, mode: 2, exp_beats: 12};

    // Reset
    rst_n = 1'b0; done = 1'b0; out_ready = 1'b0; res = '0; dim_n = '0; dim_m = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({out_valid, busy, out_data, out_row, out_col, out_last, overflow}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Table-driven jobs
    for (int i = 0; i < 7; i++) begin
      make_res(tbl[i].pat, r);
      start_job(3'(tbl[i].n), 3'(tbl[i].m), r);
      drain(tbl[i].mode, 300, -1, '0, '0, '0, 1'b0, beats, cyc);
      check("beat_count", 64'(beats), 64'(tbl[i].exp_beats));
      if (tbl[i].mode == 0) check("throughput", 64'(cyc), 64'(tbl[i].exp_beats));
      check_idle("after_job");
    end

    // Randomized jobs
    for (int i = 0; i < 15; i++) begin
      make_res(2, r);
      start_job(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), r);
      drain(2, 300, -1, '0, '0, '0, 1'b0, beats, cyc);
      check_idle("after_rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("overflow_clear", 64'(overflow), 64'(0));

    // Back-to-back: 1x1 job lands on the last beat of a 2x2 job
    make_res(2, r);
    make_res(2, r2);
    r2[DW-1:0] = 32'hDEADBEEF;
    start_job(3'd2, 3'd2, r);
    drain(0, 50, 3, 3'd1, 3'd1, r2, 1'b1, beats, cyc);
    check("b2b_beats", 64'(beats), 64'(5));
    check("b2b_no_bubble", 64'(cyc), 64'(5));
    check("b2b_overflow", 64'(overflow), 64'(0));
    check_idle("after_b2b");

    // Overflow: done at beat 5 of a 4x4 stream is dropped
    make_res(0, r);
    make_res(2, r2);
    start_job(3'd4, 3'd4, r);
    drain(0, 50, 4, 3'd2, 3'd2, r2, 1'b0, beats, cyc);
    check("ovf_beats", 64'(beats), 64'(16));
    check("ovf_set", 64'(overflow), 64'(1));
    check_idle("after_ovf");
    repeat (3) @(negedge clk);
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Reset mid-stream at beat 3, then a clamped 0x0 job
    make_res(0, r);
    start_job(3'd4, 3'd4, r);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("beat3_data", 64'(out_data), 64'(102));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 64'({out_valid, busy, out_data, out_row, out_col, out_last, overflow}), 64'(0));
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_idle");
    make_res(2, r);
    start_job(3'd0, 3'd0, r);
    drain(0, 20, -1, '0, '0, '0, 1'b0, beats, cyc);
    check("clamp_beats", 64'(beats), 64'(1));
    check_idle("after_clamp");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Downstream consumer of the matrix-multiply result vector (16 elements, row-major, slot k = row*MAX_DIM + col), which is also written into the result scratchpad.
- On the done pulse, snapshots the full result set and the active dimensions.
- Streams only the valid N x M elements out one at a time over a valid/ready interface, tagged with row/col and a last flag.
- Feeds the host/bus readout path, so the multiplier can start the next job immediately.

Parameters:
- DATA_WIDTH, 32, width of one result element.
- MAX_DIM, 4, maximum matrix dimension; buffer holds MAX_DIM*MAX_DIM elements.
- DIM_WIDTH, 3, width of dimension inputs (must represent MAX_DIM).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  synchronous active-low reset, sampled on clk_i rising edge.
- done_i  input  1  one-cycle pulse: res_i and dims valid this cycle.
- res_i  input  DATA_WIDTH*MAX_DIM*MAX_DIM  flattened results; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- dim_n_i  input  DIM_WIDTH  result rows N.
- dim_m_i  input  DIM_WIDTH  result columns M.
- out_valid_o  output  1  element presented.
- out_ready_i  input  1  consumer accepts element.
- out_data_o  output  DATA_WIDTH  element value.
- out_row_o  output  DIM_WIDTH  row index of element.
- out_col_o  output  DIM_WIDTH  column index of element.
- out_last_o  output  1  element is (N-1, M-1).
- busy_o  output  1  snapshot held, streaming in progress.
- overflow_o  output  1  sticky: done_i arrived while busy and was dropped.

Behaviour:
- Reset (rst_ni=0 at edge): state IDLE; buffer cleared to 0; all outputs 0. Reset mid-stream aborts immediately; no further handshakes.
- States: IDLE, STREAM.
- IDLE: on done_i, capture all res_i elements into the buffer and N/M (clamped: 0 -> 1, >MAX_DIM -> MAX_DIM). Set row=col=0 and go to STREAM. out_valid_o and busy_o are high from the next cycle (1-cycle latency).
- STREAM: out_data_o = buffer[row*MAX_DIM+col]; out_last_o = (row==N-1 && col==M-1).
- Transfer occurs on a cycle with out_valid_o && out_ready_i.
  - Non-last transfer: col increments; when col==M-1, col wraps to 0 and row increments.
  - Last transfer: return to IDLE; out_valid_o and busy_o low next cycle.
- Stall: while out_valid_o && !out_ready_i, all out_* outputs hold stable. out_valid_o never drops without a transfer (except on reset).
- out_ready_i is ignored when out_valid_o=0. It may be high before valid.
- done_i in STREAM, not on the last-transfer cycle: dropped; buffer untouched; overflow_o set to 1 and held until reset.
- done_i coincident with the last transfer: accepted. New snapshot captured, stays in STREAM, row/col reset to 0, out_valid_o stays high with element (0,0) of the new job next cycle (back-to-back, no bubble). overflow_o unchanged.
- Throughput: one element per cycle with out_ready_i held high; an N x M job takes N*M cycles after the first valid.
- Snapshot is independent of res_i after capture; res_i may change freely.

Optional Feature:
- Macro RESULT_STREAM_PARITY_EN.
- Defined: adds output port out_parity_o (1 bit) = XOR reduction of out_data_o. It is registered together with the data, follows the same valid/stall rules, and is 0 at reset.
- Not defined: port absent; no parity logic.

Test Plan:
- Reset then done_i with N=M=4, res_i element k = 100+k, ready always 1 -> 16 beats, data 100..115 in order, row/col (0,0)..(3,3), last only on beat 16, busy_o low the cycle after.
- N=2, M=3, res element k = k -> beats carry data 0,1,2,4,5,6 with cols 0,1,2 wrapping; last on data 6.
- N=M=4, ready toggled 1,0,0,1 pattern -> data/row/col/last stable across every stall cycle; no beat lost or duplicated.
- done_i pulsed at beat 5 of a 4x4 stream -> overflow_o=1 sticky; stream continues with original data; no restart.
- done_i (N=M=1, data 0xDEADBEEF) on the last-beat cycle of a 2x2 stream -> next cycle valid with 0xDEADBEEF, last=1, no idle gap; overflow_o stays 0.
- Assert rst_ni=0 mid-stream at beat 3 -> next cycle all outputs 0, state IDLE; a following done_i with N=M=0 streams one element (0,0) (clamp).
